hs_ram_arbiter: RTL and testbench



---
 rtl/hs_pkg.sv | 26 ++
 rtl/hs_arb_mux.sv | 32 +++
 rtl/hs_ram_arbiter.sv | 168 ++++++++++++++++
 tb/tb_hs_ram_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Purpose : shared types for the hiscore work-RAM arbiter (FSM states, mux select codes).
// Latency : n/a (types, constants and a constant-evaluation helper only).
// Backpr. : n/a.
package hs_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PAUSE_REQ = 3'd1,
        SETTLE    = 3'd2,
        GRANT     = 3'd3,
        RELEASE   = 3'd4
    } hs_arb_state_t;

    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_HS  = 1'b1;

    // Used to size the shared cycle counter from the three timing parameters.
    function automatic int hs_max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/hs_arb_mux.sv
// Purpose : combinational RAM-port mux between CPU and hiscore engine, with the hiscore write gated.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the owner of i_sel decides who drives the RAM.
// Ports   : i_sel (SEL_CPU/SEL_HS), i_hs_gate (hiscore write enable gate),
//           i_cpu_* / i_hs_* request buses in, o_ram_* muxed RAM port out.
module hs_arb_mux
    import hs_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          i_sel,
    input  logic          i_hs_gate,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [7:0]    i_cpu_dat,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_hs_addr,
    input  logic [7:0]    i_hs_dat,
    input  logic          i_hs_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [7:0]    o_ram_dat,
    output logic          o_ram_we
);

    wire w_hs_sel = (i_sel == SEL_HS);

    assign o_ram_addr = w_hs_sel ? i_hs_addr : i_cpu_addr;
    assign o_ram_dat  = w_hs_sel ? i_hs_dat  : i_cpu_dat;
    // While the hiscore side owns the port but has no grant (hold window),
    // its write strobe must never reach the RAM.
    assign o_ram_we   = w_hs_sel ? (i_hs_we & i_hs_gate) : i_cpu_we;

endmodule

// File: rtl/hs_ram_arbiter.sv
// Purpose : pauses the CPU and hands the work-RAM port to the hiscore engine on request.
// Latency : pause 1 clk after request; grant SETTLE_CYCLES+1 after pause_ack; release HOLD_CYCLES+1.
// Backpr. : hiscore waits (hs_grant=0) until the CPU is paused and the bus has settled.
// Ports   : clk, reset_n (async active-low); cpu_* and hs_* request buses; pause_ack, vblank;
//           ram_* muxed RAM port; pause_cpu, hs_grant, ack_timeout (sticky) status outputs.
// Config  : define HS_ARB_VBLANK_EN to start a takeover only while vblank=1.
module hs_ram_arbiter
    import hs_pkg::*;
#(
    parameter int AW            = 10,
    parameter int SETTLE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    input  logic          cpu_we,
    input  logic [AW-1:0] hs_address,
    input  logic [7:0]    hs_data,
    input  logic          hs_write,
    input  logic          hs_access,
    input  logic          pause_ack,
    input  logic          vblank,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_din,
    output logic          ram_we,
    output logic          pause_cpu,
    output logic          hs_grant,
    output logic          ack_timeout
);

    localparam int CNT_MAX = hs_max3(ACK_TIMEOUT, SETTLE_CYCLES, HOLD_CYCLES);
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] C_ACK    = CW'(ACK_TIMEOUT);
    localparam logic [CW-1:0] C_SETTLE = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] C_ONE    = CW'(1);

    hs_arb_state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic          r_sel,   w_sel_nxt;
    logic          r_pause, w_pause_nxt;
    logic          r_grant, w_grant_nxt;
    logic          r_to,    w_to_nxt;
    logic          w_start;

`ifdef HS_ARB_VBLANK_EN
    assign w_start = hs_access & vblank;
`else
    assign w_start = hs_access;
    logic w_unused_vblank;
    assign w_unused_vblank = vblank;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sel   <= SEL_CPU;
            r_pause <= 1'b0;
            r_grant <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_pause <= w_pause_nxt;
            r_grant <= w_grant_nxt;
            r_to    <= w_to_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_pause_nxt = r_pause;
        w_grant_nxt = r_grant;
        w_to_nxt    = r_to;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_state_nxt = PAUSE_REQ;
                    w_pause_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            PAUSE_REQ: begin
                if (!hs_access) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = C_HOLD;
                end else if (pause_ack) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = C_SETTLE;
                end else if (r_cnt >= C_ACK) begin
                    // Core never acknowledged: flag it and take the bus anyway.
                    w_to_nxt    = 1'b1;
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = C_SETTLE;
                end else begin
                    w_cnt_nxt   = r_cnt + C_ONE;
                end
            end
            SETTLE: begin
                if (!hs_access) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = C_HOLD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = SEL_HS;
                    w_grant_nxt = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            GRANT: begin
                if (!hs_access) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = C_HOLD;
                    w_grant_nxt = 1'b0;
                end
            end
            RELEASE: begin
                // CPU is still paused here, so a returning request skips settling.
                if (hs_access) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = SEL_HS;
                    w_grant_nxt = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_sel_nxt   = SEL_CPU;
                    w_pause_nxt = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sel_nxt   = SEL_CPU;
                w_pause_nxt = 1'b0;
                w_grant_nxt = 1'b0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign pause_cpu   = r_pause;
    assign hs_grant    = r_grant;
    assign ack_timeout = r_to;

    hs_arb_mux #(.AW(AW)) u_mux (
        .i_sel      (r_sel),
        .i_hs_gate  (r_grant),
        .i_cpu_addr (cpu_addr),
        .i_cpu_dat  (cpu_dout),
        .i_cpu_we   (cpu_we),
        .i_hs_addr  (hs_address),
        .i_hs_dat   (hs_data),
        .i_hs_we    (hs_write),
        .o_ram_addr (ram_addr),
        .o_ram_dat  (ram_din),
        .o_ram_we   (ram_we)
    );

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Purpose : self-checking bench for hs_ram_arbiter: directed scenarios plus randomized traffic.
// Latency : n/a.
// Backpr. : n/a.
module tb_hs_ram_arbiter;

    localparam int AW = 10;
    localparam int SC = 4;
    localparam int HC = 2;
    localparam int AT = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_dout = '0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] hs_address = '0;
    logic [7:0]    hs_data = '0;
    logic          hs_write = 1'b0;
    logic          hs_access = 1'b0;
    logic          pause_ack = 1'b0;
    logic          vblank = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_din;
    logic          ram_we;
    logic          pause_cpu;
    logic          hs_grant;
    logic          ack_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hs_ram_arbiter #(
        .AW(AW), .SETTLE_CYCLES(SC), .HOLD_CYCLES(HC), .ACK_TIMEOUT(AT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .hs_address(hs_address), .hs_data(hs_data), .hs_write(hs_write),
        .hs_access(hs_access), .pause_ack(pause_ack), .vblank(vblank),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .pause_cpu(pause_cpu), .hs_grant(hs_grant), .ack_timeout(ack_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: phases with absolute-cycle deadlines.
    // phase: 0 idle, 1 waiting for ack, 2 settling, 3 granted, 4 releasing.
    int m_n = 0;
    int m_phase = 0;
    int m_t0 = 0;
    int m_dl = 0;
    bit m_pause = 0, m_grant = 0, m_sel = 0, m_to = 0;
    bit m_go;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = 0; m_pause = 0; m_grant = 0; m_sel = 0; m_to = 0;
        end else begin
            m_n = m_n + 1;
`ifdef HS_ARB_VBLANK_EN
            m_go = hs_access && vblank;
`else
            m_go = hs_access;
`endif
            case (m_phase)
                0: if (m_go) begin m_phase = 1; m_pause = 1; m_t0 = m_n; end
                1: begin
                    if (!hs_access) begin m_phase = 4; m_dl = m_n + HC + 1; end
                    else if (pause_ack) begin m_phase = 2; m_dl = m_n + SC + 1; end
                    else if (m_n - m_t0 == AT + 1) begin
                        m_to = 1; m_phase = 2; m_dl = m_n + SC + 1;
                    end
                end
                2: begin
                    if (!hs_access) begin m_phase = 4; m_dl = m_n + HC + 1; end
                    else if (m_n == m_dl) begin m_phase = 3; m_sel = 1; m_grant = 1; end
                end
                3: if (!hs_access) begin m_phase = 4; m_grant = 0; m_dl = m_n + HC + 1; end
                default: begin
                    if (hs_access) begin m_phase = 3; m_sel = 1; m_grant = 1; end
                    else if (m_n == m_dl) begin m_phase = 0; m_sel = 0; m_pause = 0; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("pause_cpu", 32'(pause_cpu), 32'(m_pause));
            chk("hs_grant", 32'(hs_grant), 32'(m_grant));
            chk("ack_timeout", 32'(ack_timeout), 32'(m_to));
            chk("ram_addr", 32'(ram_addr), 32'(m_sel ? hs_address : cpu_addr));
            chk("ram_din", 32'(ram_din), 32'(m_sel ? hs_data : cpu_dout));
            chk("ram_we", 32'(ram_we), 32'(m_sel ? (hs_write & m_grant) : cpu_we));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int ack_mode;

    initial begin
        // Reset state
        cpu_addr = 10'h155;
        tick(2);
        chk("rst_pause", 32'(pause_cpu), 0);
        chk("rst_grant", 32'(hs_grant), 0);
        chk("rst_to", 32'(ack_timeout), 0);
        chk("rst_addr", 32'(ram_addr), 32'h155);
        reset_n = 1'b1;
        tick(1);

        // Basic grant, write gated during settle
        hs_access = 1; hs_address = 10'h2A5; hs_write = 1;
        tick(1);
        chk("basic_pause_rise", 32'(pause_cpu), 1);
        tick(2);
        pause_ack = 1;
        tick(1);
        pause_ack = 0;
        chk("settle_we_gated", 32'(ram_we), 0);
        chk("settle_no_grant", 32'(hs_grant), 0);
        tick(4);
        chk("grant_not_yet", 32'(hs_grant), 0);
        tick(1);
        chk("grant_rise", 32'(hs_grant), 1);
        chk("grant_addr", 32'(ram_addr), 32'h2A5);

        // Writes in grant
        hs_address = 10'h100; hs_data = 8'h5A; hs_write = 1;
        #1;
        chk("wr_we", 32'(ram_we), 1);
        chk("wr_addr", 32'(ram_addr), 32'h100);
        chk("wr_din", 32'(ram_din), 32'h5A);
        tick(1);
        hs_write = 0;
        #1;
        chk("wr_we_off", 32'(ram_we), 0);

        // Release with CPU write waiting
        hs_write = 1; hs_access = 0;
        cpu_addr = 10'h010; cpu_dout = 8'h77; cpu_we = 1;
        tick(1);
        chk("rel_we0", 32'(ram_we), 0);
        chk("rel_sel_hs", 32'(ram_addr), 32'h100);
        chk("rel_pause", 32'(pause_cpu), 1);
        tick(2);
        chk("rel_pause_hold", 32'(pause_cpu), 1);
        chk("rel_we0_end", 32'(ram_we), 0);
        tick(1);
        chk("rel_pause_fall", 32'(pause_cpu), 0);
        chk("cpu_wr_addr", 32'(ram_addr), 32'h010);
        chk("cpu_wr_we", 32'(ram_we), 1);
        cpu_we = 0; hs_write = 0;

        // Timeout
        hs_access = 1;
        tick(1);
        tick(8);
        chk("to_not_yet", 32'(ack_timeout), 0);
        tick(1);
        chk("to_set", 32'(ack_timeout), 1);
        tick(4);
        chk("to_grant_wait", 32'(hs_grant), 0);
        tick(1);
        chk("to_grant", 32'(hs_grant), 1);
        hs_access = 0;
        tick(4);
        chk("to_released", 32'(pause_cpu), 0);
        chk("to_sticky", 32'(ack_timeout), 1);

        // Abort during settle
        hs_access = 1;
        tick(1);
        pause_ack = 1;
        tick(1);
        pause_ack = 0;
        tick(1);
        hs_access = 0; hs_address = 10'h3FF; cpu_addr = 10'h0AA;
        tick(1);
        chk("abort_sel_cpu", 32'(ram_addr), 32'h0AA);
        chk("abort_pause", 32'(pause_cpu), 1);
        tick(3);
        chk("abort_idle", 32'(pause_cpu), 0);

        // Re-request during release
        hs_access = 1;
        tick(1);
        pause_ack = 1;
        tick(1);
        pause_ack = 0;
        tick(5);
        chk("rr_grant", 32'(hs_grant), 1);
        hs_access = 0;
        tick(1);
        chk("rr_rel_grant", 32'(hs_grant), 0);
        hs_access = 1;
        tick(1);
        chk("rr_regrant", 32'(hs_grant), 1);
        chk("rr_pause", 32'(pause_cpu), 1);

        // Async reset mid-grant
        reset_n = 0;
        #1;
        chk("arst_pause", 32'(pause_cpu), 0);
        chk("arst_grant", 32'(hs_grant), 0);
        chk("arst_to", 32'(ack_timeout), 0);
        chk("arst_addr", 32'(ram_addr), 32'h0AA);
        hs_access = 0;
        tick(2);
        reset_n = 1;
        tick(1);

`ifdef HS_ARB_VBLANK_EN
        vblank = 0; hs_access = 1;
        tick(3);
        chk("vb_wait", 32'(pause_cpu), 0);
        vblank = 1;
        tick(1);
        chk("vb_go", 32'(pause_cpu), 1);
        hs_access = 0;
        tick(5);
`endif

        // Randomized traffic against the model
        ack_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) ack_mode = int'($urandom_range(2));
            if ($urandom_range(11) == 0) hs_access = ~hs_access;
            pause_ack  = (ack_mode != 0) && ($urandom_range(3) == 0);
            hs_write   = 1'($urandom);
            hs_address = AW'($urandom);
            hs_data    = 8'($urandom);
            cpu_addr   = AW'($urandom);
            cpu_dout   = 8'($urandom);
            cpu_we     = 1'($urandom);
            vblank     = 1'($urandom);
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
